// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core's MEM stage and dmem_responder.
// The core drives the master side; the responder implements the slave side.
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              rd_en;
  logic              wd_en;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        mem_type;
  logic [31:0]       din;
  logic [31:0]       dout;
  logic              dout_valid;
  logic              busy;
  logic              err;

  modport master (
    output rd_en, wd_en, addr, mem_type, din,
    input  dout, dout_valid, busy, err
  );

  modport slave (
    input  rd_en, wd_en, addr, mem_type, din,
    output dout, dout_valid, busy, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: byte/half/word stores through
// lane enables, fixed-latency sign/zero-extended loads, busy while a load
// is in flight. Optional macro DMEM_MISALIGN_CHECK_EN drops misaligned
// accesses and flags them on err; without it err is constant 0 and the
// offending low address bits are ignored.
module dmem_responder #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned READ_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_CHECK = 1'b1;
`else
  localparam bit MIS_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [31:0] mem [DEPTH];

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   idx_q;
  logic [1:0]         lane_q;
  logic [2:0]         type_q;
  logic               rng_q;
  logic               mis_q;
  logic               latch_c;

  logic [IDX_W-1:0]   req_idx_c;
  logic               req_rng_c;
  logic               misalign_c;
  logic [3:0]         lane_we_c;
  logic [31:0]        wdata_c;
  logic               mem_we_c;
  logic [IDX_W-1:0]   ld_idx_c;
  logic [1:0]         ld_lane_c;
  logic [2:0]         ld_type_c;
  logic               ld_rng_c;
  logic               ld_mis_c;
  logic [31:0]        load_c;

  // Pick the addressed byte/half/word and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  lane,
                                          input logic [2:0]  mt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (mt[1:0])
      2'b00:   r = mt[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = mt[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Request decode: range, alignment, lane enables and replicated store data.
  always_comb begin
    req_idx_c  = bus.addr[ADDR_W-1:2];
    req_rng_c  = (32'(req_idx_c) < DEPTH);
    misalign_c = MIS_CHECK &&
                 (((bus.mem_type[1:0] == 2'b01) && bus.addr[0]) ||
                  (bus.mem_type[1] && (bus.addr[1:0] != 2'b00)));
    case (bus.mem_type[1:0])
      2'b00: begin
        lane_we_c = 4'b0001 << bus.addr[1:0];
        wdata_c   = {4{bus.din[7:0]}};
      end
      2'b01: begin
        lane_we_c = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_c   = {2{bus.din[15:0]}};
      end
      default: begin
        lane_we_c = 4'b1111;
        wdata_c   = bus.din;
      end
    endcase
    mem_we_c = (state_q == IDLE) && bus.wd_en && req_rng_c && !misalign_c;
  end

  // Load source: live request when answering straight from IDLE, else the latched one.
  always_comb begin
    if (state_q == IDLE) begin
      ld_idx_c  = req_idx_c;
      ld_lane_c = bus.addr[1:0];
      ld_type_c = bus.mem_type;
      ld_rng_c  = req_rng_c;
      ld_mis_c  = misalign_c;
    end else begin
      ld_idx_c  = idx_q;
      ld_lane_c = lane_q;
      ld_type_c = type_q;
      ld_rng_c  = rng_q;
      ld_mis_c  = mis_q;
    end
    load_c = (ld_rng_c && !ld_mis_c)
             ? extract(mem[ld_idx_c[MEM_AW-1:0]], ld_lane_c, ld_type_c)
             : 32'h0;
  end

  // Byte-lane writes; the array is not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we_c[i]) mem[req_idx_c[MEM_AW-1:0]][8*i +: 8] <= wdata_c[8*i +: 8];
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    latch_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wd_en) begin
          err_d = misalign_c;
        end else if (bus.rd_en) begin
          latch_c = 1'b1;
          if (READ_LAT <= 1) begin
            state_d = RESP;
            valid_d = 1'b1;
            dout_d  = load_c;
            err_d   = misalign_c;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(READ_LAT - 1);
            busy_d  = 1'b1;
          end
        end
      end
      WAIT: begin
        // Respond on the edge where the count reaches zero, READ_LAT edges after acceptance.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = RESP;
          valid_d = 1'b1;
          dout_d  = load_c;
          err_d   = mis_q;
        end else begin
          busy_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Capture the accepted load's address, size and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      lane_q <= '0;
      type_q <= '0;
      rng_q  <= 1'b0;
      mis_q  <= 1'b0;
    end else if (latch_c) begin
      idx_q  <= req_idx_c;
      lane_q <= bus.addr[1:0];
      type_q <= bus.mem_type;
      rng_q  <= req_rng_c;
      mis_q  <= misalign_c;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table of stores/loads with
// hand-computed results, plus sequences for simultaneous requests,
// requests during WAIT and reset in the middle of a load.
module tb_dmem_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 200;
  localparam int unsigned RL     = 2;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  localparam logic [2:0] BS = 3'b000;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HS = 3'b001;
  localparam logic [2:0] HU = 3'b101;
  localparam logic [2:0] WD = 3'b010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LAT(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ld;
    logic [9:0]  addr;
    logic [2:0]  mt;
    logic [31:0] din;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic add(input logic ld, input logic [9:0] a, input logic [2:0] mt,
                     input logic [31:0] din, input logic [31:0] exp, input logic exp_err);
    vec_t v;
    v.ld = ld; v.addr = a; v.mt = mt; v.din = din; v.exp = exp; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.rd_en = 1'b0; bus.wd_en = 1'b0; bus.addr = '0; bus.mem_type = '0; bus.din = '0;
  endtask

  task automatic do_store(input string nm, input logic [9:0] a, input logic [2:0] mt,
                          input logic [31:0] din, input logic exp_err);
    @(negedge clk);
    bus.wd_en = 1'b1; bus.addr = a; bus.mem_type = mt; bus.din = din;
    @(negedge clk);
    idle_inputs();
    check({nm, " st busy"}, 32'(bus.busy), 32'h0);
    check({nm, " st valid"}, 32'(bus.dout_valid), 32'h0);
    check({nm, " st err"}, 32'(bus.err), 32'(exp_err));
  endtask

  task automatic do_load(input string nm, input logic [9:0] a, input logic [2:0] mt,
                         input logic [31:0] exp, input logic exp_err);
    int n;
    @(negedge clk);
    bus.rd_en = 1'b1; bus.addr = a; bus.mem_type = mt;
    @(negedge clk);
    idle_inputs();
    n = 1;
    check({nm, " ld busy"}, 32'(bus.busy), 32'(RL > 1));
    while (bus.dout_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, " ld latency"}, 32'(n), 32'(RL));
    check({nm, " ld dout"}, bus.dout, exp);
    check({nm, " ld err"}, 32'(bus.err), 32'(exp_err));
    @(negedge clk);
    check({nm, " ld pulse end"}, 32'({bus.dout_valid, bus.busy}), 32'h0);
    check({nm, " ld hold"}, bus.dout, exp);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    idle_inputs();

    // Store/load table; misaligned rows depend on the build option.
    add(0, 10'h010, WD, 32'hDEADBEEF, 32'h0, 0);
    add(1, 10'h010, WD, 32'h0, 32'hDEADBEEF, 0);
    add(0, 10'h010, WD, 32'h11223344, 32'h0, 0);
    add(0, 10'h013, BS, 32'hFFFFFF80, 32'h0, 0);
    add(1, 10'h013, BS, 32'h0, 32'hFFFFFF80, 0);
    add(1, 10'h013, BU, 32'h0, 32'h00000080, 0);
    add(1, 10'h010, WD, 32'h0, 32'h80223344, 0);
    add(1, 10'h011, BS, 32'h0, 32'h00000033, 0);
    add(1, 10'h012, BU, 32'h0, 32'h00000022, 0);
    add(0, 10'h020, WD, 32'h76543210, 32'h0, 0);
    add(0, 10'h022, HS, 32'h1234A5A5, 32'h0, 0);
    add(1, 10'h022, HS, 32'h0, 32'hFFFFA5A5, 0);
    add(1, 10'h022, HU, 32'h0, 32'h0000A5A5, 0);
    add(1, 10'h020, HS, 32'h0, 32'h00003210, 0);
    add(1, 10'h020, WD, 32'h0, 32'hA5A53210, 0);
    add(0, 10'h021, BU, 32'h000000EE, 32'h0, 0);
    add(1, 10'h020, WD, 32'h0, 32'hA5A5EE10, 0);
    add(1, 10'h020, HS, 32'h0, 32'hFFFFEE10, 0);
    add(0, 10'h3FC, WD, 32'hFFFFFFFF, 32'h0, 0);
    add(1, 10'h3FC, WD, 32'h0, 32'h00000000, 0);
    add(0, 10'h004, WD, 32'h00000000, 32'h0, 0);
    add(0, 10'h006, WD, 32'h11111111, 32'h0, MC);
    add(1, 10'h004, WD, 32'h0, MC ? 32'h0 : 32'h11111111, 0);
    add(1, 10'h005, WD, 32'h0, MC ? 32'h0 : 32'h11111111, MC);
    add(1, 10'h023, HS, 32'h0, MC ? 32'h0 : 32'hFFFFA5A5, MC);
    add(0, 10'h023, HS, 32'h00005A5A, 32'h0, MC);
    add(1, 10'h020, WD, 32'h0, MC ? 32'hA5A5EE10 : 32'h5A5AEE10, 0);

    // Reset values.
    repeat (2) @(negedge clk);
    check("reset dout", bus.dout, 32'h0);
    check("reset flags", 32'({bus.dout_valid, bus.busy, bus.err}), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].ld)
        do_load($sformatf("vec%0d", i), vecs[i].addr, vecs[i].mt, vecs[i].exp, vecs[i].exp_err);
      else
        do_store($sformatf("vec%0d", i), vecs[i].addr, vecs[i].mt, vecs[i].din, vecs[i].exp_err);
    end

    // Load and store together: the store wins, no response.
    @(negedge clk);
    bus.rd_en = 1'b1; bus.wd_en = 1'b1; bus.addr = 10'h030; bus.mem_type = WD; bus.din = 32'h12345678;
    @(negedge clk);
    idle_inputs();
    seen = 0;
    repeat (4) begin
      if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
      @(negedge clk);
    end
    check("rdwd no response", 32'(seen), 32'h0);
    do_load("rdwd", 10'h030, WD, 32'h12345678, 0);

    // A store presented while a load waits is ignored.
    do_store("pre", 10'h040, WD, 32'hCAFEF00D, 0);
    @(negedge clk);
    bus.rd_en = 1'b1; bus.addr = 10'h010; bus.mem_type = WD;
    @(negedge clk);
    idle_inputs();
    bus.wd_en = 1'b1; bus.addr = 10'h040; bus.mem_type = WD; bus.din = 32'h0;
    @(negedge clk);
    idle_inputs();
    check("wait valid", 32'(bus.dout_valid), 32'h1);
    check("wait dout", bus.dout, 32'h80223344);
    do_load("wait ignore", 10'h040, WD, 32'hCAFEF00D, 0);

    // Reset one cycle after acceptance aborts the load.
    @(negedge clk);
    bus.rd_en = 1'b1; bus.addr = 10'h020; bus.mem_type = WD;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    check("abort busy", 32'(bus.busy), 32'h0);
    check("abort valid", 32'(bus.dout_valid), 32'h0);
    check("abort dout", bus.dout, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.dout_valid !== 1'b0) seen++;
    end
    check("abort no valid", 32'(seen), 32'h0);
    do_load("after reset", 10'h010, WD, 32'h80223344, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
